// File: rtl/uart_rx_if.sv
// Receive-side bundle between the UART core (master) and its consumer (slave).
// The serial line rides along so the core has a single bus port.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// Counter-timed UART receiver: 2-flop synchroniser, start/data/parity/stop FSM,
// and a one-word holding register with valid/ready hand-off and overrun flag.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
  logic                 fall;

  assign fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= bus.rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    valid_d    = valid_q & ~bus.rx_ready;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = (^{shift_q, rx_s_q}) != (PARITY == 1);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_s_q;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
            // The holding register only takes the new word if it is free or
            // being emptied on this same edge; otherwise the frame is lost.
            if (!valid_q || bus.rx_ready) begin
              data_d     = shift_q;
              perr_out_d = perr_q;
              ferr_out_d = ferr_q | ~rx_s_q;
              valid_d    = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_out_q;
  assign bus.frame_err  = ferr_out_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: three instances (8N1, 8E1, 8N2) fed with
// directed frames; a negedge monitor pops expected words on each acceptance.
module tb_uart_rx_core;
  localparam int C = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxl = '1;
  logic [2:0] rdy = '1;
  int         cyc = 0;

  exp_t       expq[3][$];
  int         checks = 0;
  int         errors = 0;
  int         rise_cyc[3];
  int         vhigh[3];
  int         ovr_cnt[3];
  int         start_cyc[3];
  logic [2:0] vprev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if #(.DATA_BITS(8)) b0 ();
  uart_rx_if #(.DATA_BITS(8)) b1 ();
  uart_rx_if #(.DATA_BITS(8)) b2 ();

  assign b0.rx = rxl[0];
  assign b1.rx = rxl[1];
  assign b2.rx = rxl[2];
  assign b0.rx_ready = rdy[0];
  assign b1.rx_ready = rdy[1];
  assign b2.rx_ready = rdy[2];

  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    return e;
  endfunction

  // {valid, busy, parity_err, frame_err, overrun, rx_data}
  function automatic logic [12:0] outs(input int i);
    case (i)
      0:       return {b0.rx_valid, b0.busy, b0.parity_err, b0.frame_err, b0.overrun, b0.rx_data};
      1:       return {b1.rx_valid, b1.busy, b1.parity_err, b1.frame_err, b1.overrun, b1.rx_data};
      default: return {b2.rx_valid, b2.busy, b2.parity_err, b2.frame_err, b2.overrun, b2.rx_data};
    endcase
  endfunction

  task automatic mon(input int i, input logic v, input logic r, input logic [7:0] d,
                     input logic pe, input logic fe, input logic ov);
    exp_t e;
    if (v && !vprev[i]) rise_cyc[i] = cyc;
    vprev[i] = v;
    if (v) vhigh[i]++;
    if (ov) ovr_cnt[i]++;
    if (v && r) begin
      if (expq[i].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word u%0d: got %0h expected none", i, d);
      end else begin
        e = expq[i].pop_front();
        chk($sformatf("data_u%0d", i), {24'h0, d}, {24'h0, e.d});
        chk($sformatf("parity_err_u%0d_%0h", i, e.d), {31'h0, pe}, {31'h0, e.pe});
        chk($sformatf("frame_err_u%0d_%0h", i, e.d), {31'h0, fe}, {31'h0, e.fe});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.rx_valid, b0.rx_ready, b0.rx_data, b0.parity_err, b0.frame_err, b0.overrun);
    mon(1, b1.rx_valid, b1.rx_ready, b1.rx_data, b1.parity_err, b1.frame_err, b1.overrun);
    mon(2, b2.rx_valid, b2.rx_ready, b2.rx_data, b2.parity_err, b2.frame_err, b2.overrun);
  end

  task automatic drive_bit(input int i, input logic b);
    rxl[i] = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input bit has_par,
                            input logic pbit, input int nstop, input logic [1:0] stopv);
    @(posedge clk);
    #1;
    start_cyc[i] = cyc;
    drive_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(i, d[k]);
    if (has_par) drive_bit(i, pbit);
    for (int k = 0; k < nstop; k++) drive_bit(i, stopv[k]);
    rxl[i] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_u0", {19'h0, outs(0)}, 32'h0);
    chk("reset_u1", {19'h0, outs(1)}, 32'h0);
    chk("reset_u2", {19'h0, outs(2)}, 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 0xA5: latency from start-bit drive = 2 sync + 8 + 9*16 + 1
    expq[0].push_back(mk(8'hA5, 1'b0, 1'b0));
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01);
    chk("a5_latency", rise_cyc[0] - start_cyc[0], 155);
    chk("a5_valid_width", vhigh[0], 1);

    // 8E1: 0x07 has three ones, so even parity needs parity bit 1
    expq[1].push_back(mk(8'h07, 1'b0, 1'b0));
    send_frame(1, 8'h07, 1'b1, 1'b1, 1, 2'b01);
    expq[1].push_back(mk(8'h07, 1'b1, 1'b0));
    send_frame(1, 8'h07, 1'b1, 1'b0, 1, 2'b01);

    // 8N2: second stop low, then a clean frame
    expq[2].push_back(mk(8'h3C, 1'b0, 1'b1));
    send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 2'b01);
    repeat (C) @(posedge clk);
    #1;
    expq[2].push_back(mk(8'h11, 1'b0, 1'b0));
    send_frame(2, 8'h11, 1'b0, 1'b0, 2, 2'b11);

    // Overrun: consumer stalled across two back-to-back frames
    rdy[0] = 1'b0;
    expq[0].push_back(mk(8'h12, 1'b0, 1'b0));
    send_frame(0, 8'h12, 1'b0, 1'b0, 1, 2'b01);
    send_frame(0, 8'h34, 1'b0, 1'b0, 1, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    chk("overrun_pulses", ovr_cnt[0], 1);
    chk("held_data", {24'h0, b0.rx_data}, 32'h12);
    chk("held_valid", {31'h0, b0.rx_valid}, 32'h1);
    rdy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("overrun_drained", expq[0].size(), 0);
    chk("valid_after_accept", {31'h0, b0.rx_valid}, 32'h0);

    // 3-cycle glitch: false start, busy clears at t0+9 (t0 = drive+2)
    @(posedge clk);
    #1;
    c0 = cyc;
    rxl[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxl[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("glitch_busy_high", {31'h0, b0.busy}, 32'h1);
    repeat (7) @(posedge clk);
    #1;
    chk("glitch_cycle", cyc - c0, 11);
    chk("glitch_busy_low", {31'h0, b0.busy}, 32'h0);
    repeat (C) @(posedge clk);
    #1;
    expq[0].push_back(mk(8'h55, 1'b0, 1'b0));
    send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b01);

    // Reset during data bit 4 of a 0x0F frame
    repeat (C) @(posedge clk);
    #1;
    drive_bit(0, 1'b0);
    for (int k = 0; k < 4; k++) drive_bit(0, 1'b1);
    rxl[0] = 1'b0;
    repeat (C / 2) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'h0, b0.busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_reset_u0", {19'h0, outs(0)}, 32'h0);
    rxl[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2 * C) @(posedge clk);
    #1;
    chk("post_reset_idle", {19'h0, outs(0)}, 32'h0);
    expq[0].push_back(mk(8'hC3, 1'b0, 1'b0));
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 2'b01);

    for (int k = 0; k < 2000; k++) begin
      if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_u0", expq[0].size(), 0);
    chk("drain_u1", expq[1].size(), 0);
    chk("drain_u2", expq[2].size(), 0);
    chk("overrun_total_u0", ovr_cnt[0], 1);
    chk("overrun_total_u1", ovr_cnt[1], 0);
    chk("overrun_total_u2", ovr_cnt[2], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receiver with a counter-based bit-timing engine. It replaces the edge-driven prototype receiver with a clocked design. It deserialises a configurable frame on rx and checks parity and stop bits. Each received word is delivered on a valid/ready interface, with error flags attached. It sits between the pad-level rx line and the byte-stream consumers (command parser, loopback tx).

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; legal range >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9, sent LSB first.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received word
rx_valid  output  1  rx_data and the error flags are valid
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
parity_err  output  1  parity mismatch on the held word; qualified by rx_valid
frame_err  output  1  a stop bit sampled low on the held word; qualified by rx_valid
overrun  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - rx_data = 0; rx_valid, parity_err, frame_err and overrun = 0; busy = 0.
  - State = IDLE; counters = 0; synchroniser flops = 1.
- Synchroniser:
  - rx passes through 2 flops to give rx_s.
  - The FSM uses only rx_s.
  - Edge detect compares rx_s with a third registered copy of it.
- Timing, for H = CLKS_PER_BIT/2 (integer division):
  - t0 is the cycle in which a falling edge on rx_s is detected in IDLE.
  - The start bit is sampled at t0+H.
  - Frame bit k (k = 0 is the first data bit) is sampled at t0+H+(k+1)*CLKS_PER_BIT.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on a falling edge of rx_s, go to START and clear the cycle counter. A line held low never retriggers; a falling edge is required.
  - START: at the start sample, if rx_s = 1 this is a false start; return to IDLE, with no output and no flags. Otherwise go to DATA.
  - DATA: shift in DATA_BITS samples, LSB first. After the last sample, go to PAR if PARITY != 0, else go to STOP.
  - PAR: take one sample. It is an error if the XOR of the data bits and the parity bit is not 1 (odd mode) or not 0 (even mode).
  - STOP: take STOP_BITS samples. Any sample at 0 sets frame_err for the frame. After the last sample, complete the frame and go directly to IDLE, so a following start bit is caught with no dead time.
- Completion, in the cycle after the last stop sample:
  - rx_valid = 0, or rx_ready = 1 in that cycle: load rx_data, parity_err and frame_err; rx_valid = 1.
  - rx_valid = 1 and rx_ready = 0: drop the new frame; the held word and its flags are unchanged; overrun pulses for 1 cycle.
- Frames with errors are still delivered, with the flags set. The consumer decides whether to discard them.
- Handshake:
  - rx_valid stays high, and rx_data and the flags are stable, until the cycle of acceptance.
  - Acceptance happens on a clock edge with rx_valid && rx_ready; rx_valid then falls on that edge unless a completion coincides.
  - rx_ready has no combinational path to any output.
- Reset mid-frame: asynchronously abort to IDLE; the partial frame is discarded; no flags.
- The counters are sized to $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1). The cycle counter reloads to 0 on every sample; there is no cumulative drift.

Test Plan:
- 8N1, CLKS_PER_BIT = 16, send 0xA5, rx_ready = 1 -> rx_valid high 1 cycle, rx_data = 0xA5, both error flags 0; rx_valid rises at t0+8+9*16+1.
- PARITY = 2, 8 data bits, send 0x07 with parity bit 1 -> rx_data = 0x07, parity_err = 0; then send parity bit 0 -> parity_err = 1, data still delivered.
- STOP_BITS = 2, send 0x3C with the second stop bit low -> frame_err = 1, rx_data = 0x3C; the next frame 0x11 with good stops is received cleanly.
- rx_ready = 0, send 0x12 then 0x34 back-to-back -> rx_data holds 0x12, overrun pulses once at the second completion; raising rx_ready then yields 0x12 only.
- Low glitch on rx of 3 cycles (< H) -> no output, busy returns to 0 by t0+9; then a 0x55 frame is received correctly.
- Assert rst during data bit 4 of a frame -> all outputs 0 immediately; no rx_valid for that frame; the next full frame, 0xC3, is received.
